// File: rtl/rpn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rpn_pkg
//  Description : Shared definitions for the result transmit path: the
//                sequencing state enum, ASCII constants, the default UART
//                bit period and the double-dabble helper functions.
//  Revision    : 1.0  initial release
// ============================================================================
package rpn_pkg;

    // 115200 baud from a 125 MHz clock
    localparam int DEFAULT_CLKS_PER_BIT = 1085;

    // Five BCD digits cover the full 16-bit magnitude (max 65535)
    localparam int BCD_DIGITS = 5;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [7:0] C_ASCII_ZERO  = 8'h30;
    localparam logic [7:0] C_ASCII_MINUS = 8'h2D;
    localparam logic [7:0] C_ASCII_NL    = 8'h0A;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        SIGN    = 3'd2,
        DIGIT   = 3'd3,
        NEWLINE = 3'd4
    } state_t;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    // Index of the most significant non-zero digit; 0 when the value is zero
    // so that a single '0' is still emitted.
    function automatic logic [2:0] lead_digit(input logic [BCD_W-1:0] bcd);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 byte serializer. A start request is taken when idle or
//                in the final cycle of a stop bit, so frames can run back to
//                back with no idle cycle between them.
//  Ports       : clk     - clock
//                rst     - asynchronous active-high reset
//                i_byte  - byte to send, captured with i_start
//                i_start - launch request
//                o_tx    - serial line, idle high
//                o_done  - high in the last cycle of the stop bit
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_byte
    import rpn_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_byte,
    input  logic       i_start,
    output logic       o_tx,
    output logic       o_done
);

    localparam int              CNT_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] C_BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       C_LAST_BIT  = 4'd9;

    logic             r_active;
    logic [9:0]       r_shift;
    logic [3:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_baud_cnt;

    logic w_bit_end;
    logic w_frame_end;
    logic w_load;

    assign w_bit_end   = r_active && (r_baud_cnt == C_BAUD_LAST);
    assign w_frame_end = w_bit_end && (r_bit_cnt == C_LAST_BIT);
    assign w_load      = i_start && (!r_active || w_frame_end);

    assign o_done = w_frame_end;
    assign o_tx   = r_active ? r_shift[0] : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active   <= 1'b0;
            r_shift    <= '1;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
        end else if (w_load) begin
            // stop bit, data LSB first, start bit in position 0
            r_active   <= 1'b1;
            r_shift    <= {1'b1, i_byte, 1'b0};
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_baud_cnt <= '0;
                if (r_bit_cnt == C_LAST_BIT) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shift   <= {1'b1, r_shift[9:1]};
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : result_uart_tx
//  Description : Takes a 16-bit result, converts it to decimal with a
//                sequential double-dabble, and sends it over a UART as ASCII
//                digits (leading zeros suppressed) followed by '\n'.
//                Build option: define RESULT_TX_SIGNED_EN to treat num as
//                two's complement and prefix negative values with '-'.
//  Ports       : clk       - clock, rising edge
//                rst       - asynchronous active-high reset
//                num_valid - result available
//                num       - result value
//                num_ready - idle, a result can be accepted
//                tx_out    - UART line, 8N1, idle high
//                busy      - accept through end of the '\n' stop bit
//  Revision    : 1.0  initial release
// ============================================================================
module result_uart_tx
    import rpn_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NUM_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 num_valid,
    input  logic [NUM_WIDTH-1:0] num,
    output logic                 num_ready,
    output logic                 tx_out,
    output logic                 busy
);

    state_t               r_state;
    state_t               w_state_next;
    logic [NUM_WIDTH-1:0] r_shift;
    logic [BCD_W-1:0]     r_bcd;
    logic [3:0]           r_conv_cnt;
    logic [2:0]           r_idx;
    logic                 r_neg;
    logic                 r_pending;   // first frame of the string not yet launched

    logic                 w_accept;
    logic                 w_conv_last;
    logic [BCD_W-1:0]     w_bcd_adj;
    logic [BCD_W-1:0]     w_bcd_next;
    logic [2:0]           w_idx_dec;
    logic [7:0]           w_digit_byte;
    logic [7:0]           w_prev_digit_byte;
    logic                 w_neg_in;
    logic [NUM_WIDTH-1:0] w_mag_in;
    logic                 w_start;
    logic [7:0]           w_byte;
    logic                 w_done;

`ifdef RESULT_TX_SIGNED_EN
    // Magnitude of 16'h8000 wraps to 16'h8000, which reads correctly as 32768
    assign w_neg_in = num[NUM_WIDTH-1];
    assign w_mag_in = num[NUM_WIDTH-1] ? (~num + NUM_WIDTH'(1)) : num;
`else
    assign w_neg_in = 1'b0;
    assign w_mag_in = num;
`endif

    assign w_accept    = num_valid && (r_state == IDLE);
    assign w_conv_last = (r_conv_cnt == 4'(NUM_WIDTH - 1));

    assign w_bcd_adj  = bcd_adjust(r_bcd);
    assign w_bcd_next = (w_bcd_adj << 1) | BCD_W'(r_shift[NUM_WIDTH-1]);

    assign w_idx_dec         = r_idx - 3'd1;
    assign w_digit_byte      = C_ASCII_ZERO + {4'b0000, r_bcd[{r_idx, 2'b00} +: 4]};
    assign w_prev_digit_byte = C_ASCII_ZERO + {4'b0000, r_bcd[{w_idx_dec, 2'b00} +: 4]};

    assign num_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next byte is chosen in the same cycle the previous stop bit ends so
    // the serializer can chain frames without a gap.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_byte       = C_ASCII_NL;
        case (r_state)
            IDLE: begin
                if (num_valid) begin
                    w_state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (w_conv_last) begin
                    w_state_next = r_neg ? SIGN : DIGIT;
                end
            end
            SIGN: begin
                if (r_pending) begin
                    w_start = 1'b1;
                    w_byte  = C_ASCII_MINUS;
                end else if (w_done) begin
                    w_start      = 1'b1;
                    w_byte       = w_digit_byte;
                    w_state_next = DIGIT;
                end
            end
            DIGIT: begin
                if (r_pending) begin
                    w_start = 1'b1;
                    w_byte  = w_digit_byte;
                end else if (w_done) begin
                    w_start = 1'b1;
                    if (r_idx == 3'd0) begin
                        w_byte       = C_ASCII_NL;
                        w_state_next = NEWLINE;
                    end else begin
                        w_byte = w_prev_digit_byte;
                    end
                end
            end
            NEWLINE: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_bcd      <= '0;
            r_conv_cnt <= '0;
            r_idx      <= '0;
            r_neg      <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_pending <= (r_state == CONVERT) && w_conv_last;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift    <= w_mag_in;
                        r_neg      <= w_neg_in;
                        r_bcd      <= '0;
                        r_conv_cnt <= '0;
                    end
                end
                CONVERT: begin
                    r_bcd      <= w_bcd_next;
                    r_shift    <= r_shift << 1;
                    r_conv_cnt <= r_conv_cnt + 4'd1;
                    if (w_conv_last) begin
                        r_idx <= lead_digit(w_bcd_next);
                    end
                end
                DIGIT: begin
                    if (!r_pending && w_done && (r_idx != 3'd0)) begin
                        r_idx <= w_idx_dec;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk    (clk),
        .rst    (rst),
        .i_byte (w_byte),
        .i_start(w_start),
        .o_tx   (tx_out),
        .o_done (w_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_result_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_uart_tx
//  Description : Directed bench for result_uart_tx with CLKS_PER_BIT=4. A
//                bench-side UART receiver decodes tx_out into a byte queue
//                with start/end cycle stamps.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_result_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        num_valid = 1'b0;
    logic [15:0] num = 16'h0000;
    logic        num_ready;
    logic        tx_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    result_uart_tx #(
        .CLKS_PER_BIT(4),
        .NUM_WIDTH   (16)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .num_valid(num_valid),
        .num      (num),
        .num_ready(num_ready),
        .tx_out   (tx_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: bit k of a frame spans cycles 4k..4k+3 from the first low cycle
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    int         rx_end_q[$];
    int         rx_frame_err = 0;
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx_out === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
                rx_start_q.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 2 && tx_out !== 1'b0) rx_frame_err++;
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_data[(rx_cnt - 6) / 4] = tx_out;
            if (rx_cnt == 38 && tx_out !== 1'b1) rx_frame_err++;
            if (rx_cnt == 39) begin
                rx_q.push_back(rx_data);
                rx_end_q.push_back(cyc);
                rx_busy = 1'b0;
            end
        end
    end

    function automatic string q_to_hex();
        string s;
        s = "";
        foreach (rx_q[i]) s = {s, $sformatf("%02x ", rx_q[i])};
        return s;
    endfunction

    task automatic clear_rx();
        rx_q.delete();
        rx_start_q.delete();
        rx_end_q.delete();
        rx_frame_err = 0;
    endtask

    task automatic send_num(input logic [15:0] v, output int acc_cyc, output bit ok);
        @(posedge clk); #2;
        num       = v;
        num_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (num_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        acc_cyc = cyc;
        @(posedge clk); #1;
        num_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, output bit ok, output int ready_hi, output int busy_lo);
        ok = 1'b0; ready_hi = 0; busy_lo = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            if (num_ready) ready_hi++;
            if (!busy) busy_lo++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (tx_out !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b expected 1", tx_out); end
        checks++; if (num_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", num_ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checks++; if (tx_out !== 1'b1 || num_ready !== 1'b1) begin
            errors++; $display("FAIL idle_after_reset: tx=%b ready=%b expected 1 1", tx_out, num_ready);
        end
    endtask

    task automatic test_basic();
        int acc; bit ok; int rh; int bl;
        clear_rx();
        send_num(16'd25, acc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_accept: timeout waiting num_ready"); end
        wait_bytes(3, ok, rh, bl);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done: got %0d bytes expected 3", rx_q.size()); end
        checks++; if (rh !== 0) begin errors++; $display("FAIL basic_ready_low: num_ready high %0d cycles expected 0", rh); end
        checks++; if (bl !== 0) begin errors++; $display("FAIL basic_busy_high: busy low %0d cycles expected 0", bl); end
        checks++; if (num_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_release: ready=%b busy=%b expected 1 0", num_ready, busy);
        end
        checks++; if (q_to_hex() != "32 35 0a ") begin errors++; $display("FAIL basic_bytes: got %s expected 32 35 0a", q_to_hex()); end
        checks++; if (rx_frame_err !== 0) begin errors++; $display("FAIL basic_framing: got %0d errors expected 0", rx_frame_err); end
        if (rx_start_q.size() >= 2 && rx_end_q.size() >= 1) begin
            checks++; if (rx_start_q[0] - acc > 18) begin
                errors++; $display("FAIL basic_latency: got %0d cycles expected <= 18", rx_start_q[0] - acc);
            end
            checks++; if (rx_start_q[1] !== rx_end_q[0] + 1) begin
                errors++; $display("FAIL basic_b2b_frame: start %0d expected %0d", rx_start_q[1], rx_end_q[0] + 1);
            end
        end else begin
            checks++; errors++; $display("FAIL basic_stamps: got %0d starts expected >= 2", rx_start_q.size());
        end
    endtask

    task automatic test_zero();
        int acc; bit ok; int rh; int bl;
        clear_rx();
        send_num(16'd0, acc, ok);
        wait_bytes(2, ok, rh, bl);
        repeat (60) @(posedge clk);
        #2;
        checks++; if (!ok || q_to_hex() != "30 0a ") begin errors++; $display("FAIL zero_bytes: got %s expected 30 0a", q_to_hex()); end
        checks++; if (rx_frame_err !== 0) begin errors++; $display("FAIL zero_framing: got %0d expected 0", rx_frame_err); end
    endtask

    task automatic test_extremes();
        int acc; bit ok; int rh; int bl;
`ifdef RESULT_TX_SIGNED_EN
        clear_rx();
        send_num(16'h8000, acc, ok);
        wait_bytes(7, ok, rh, bl);
        checks++; if (!ok || q_to_hex() != "2d 33 32 37 36 38 0a ") begin
            errors++; $display("FAIL min_neg: got %s expected 2d 33 32 37 36 38 0a", q_to_hex());
        end
        checks++; if (rx_start_q.size() > 0 && rx_start_q[0] - acc > 18) begin
            errors++; $display("FAIL min_neg_latency: got %0d expected <= 18", rx_start_q[0] - acc);
        end
        clear_rx();
        send_num(16'hFFFF, acc, ok);
        wait_bytes(3, ok, rh, bl);
        checks++; if (!ok || q_to_hex() != "2d 31 0a ") begin
            errors++; $display("FAIL minus_one: got %s expected 2d 31 0a", q_to_hex());
        end
`else
        clear_rx();
        send_num(16'hFFFF, acc, ok);
        wait_bytes(6, ok, rh, bl);
        checks++; if (!ok || q_to_hex() != "36 35 35 33 35 0a ") begin
            errors++; $display("FAIL max_unsigned: got %s expected 36 35 35 33 35 0a", q_to_hex());
        end
        clear_rx();
        send_num(16'h8000, acc, ok);
        wait_bytes(6, ok, rh, bl);
        checks++; if (!ok || q_to_hex() != "33 32 37 36 38 0a ") begin
            errors++; $display("FAIL msb_unsigned: got %s expected 33 32 37 36 38 0a", q_to_hex());
        end
`endif
        checks++; if (rx_frame_err !== 0) begin errors++; $display("FAIL extremes_framing: got %0d expected 0", rx_frame_err); end
    endtask

    task automatic test_ignore_busy();
        int acc; bit ok; int rh; int bl;
        clear_rx();
        send_num(16'd7, acc, ok);
        repeat (20) @(posedge clk);
        #2;
        num       = 16'd9;
        num_valid = 1'b1;
        checks++; if (num_ready !== 1'b0) begin errors++; $display("FAIL ignore_ready: got %b expected 0", num_ready); end
        repeat (3) @(posedge clk);
        #2;
        num_valid = 1'b0;
        wait_bytes(2, ok, rh, bl);
        repeat (80) @(posedge clk);
        #2;
        checks++; if (!ok || q_to_hex() != "37 0a ") begin errors++; $display("FAIL ignore_bytes: got %s expected 37 0a", q_to_hex()); end
        checks++; if (num_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ignore_idle: ready=%b busy=%b expected 1 0", num_ready, busy);
        end
    endtask

    task automatic test_reset_midframe();
        int acc; bit ok; int rh; int bl; bit hit;
        clear_rx();
        send_num(16'd25, acc, ok);
        wait_bytes(1, ok, rh, bl);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (rx_busy && rx_cnt >= 8) begin
                hit = 1'b1;
                break;
            end
        end
        checks++; if (!hit || tx_out !== 1'b0) begin
            errors++; $display("FAIL midframe_setup: reached=%b tx=%b expected 1 0", hit, tx_out);
        end
        rst = 1'b1;
        #1;
        checks++; if (tx_out !== 1'b1)    begin errors++; $display("FAIL rst_async_tx: got %b expected 1", tx_out); end
        checks++; if (num_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b expected 1", num_ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        clear_rx();
        repeat (100) @(posedge clk);
        #2;
        checks++; if (rx_start_q.size() !== 0 || tx_out !== 1'b1) begin
            errors++; $display("FAIL no_resume: got %0d frames tx=%b expected 0 1", rx_start_q.size(), tx_out);
        end
        send_num(16'd3, acc, ok);
        wait_bytes(2, ok, rh, bl);
        checks++; if (!ok || q_to_hex() != "33 0a ") begin errors++; $display("FAIL after_rst_bytes: got %s expected 33 0a", q_to_hex()); end
        checks++; if (rx_frame_err !== 0) begin errors++; $display("FAIL after_rst_framing: got %0d expected 0", rx_frame_err); end
    endtask

    task automatic test_back_to_back();
        bit ok; int rh; int bl;
        clear_rx();
        @(posedge clk); #2;
        num       = 16'd12;
        num_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (num_ready) begin ok = 1'b1; break; end
            @(posedge clk); #2;
        end
        @(posedge clk); #1;
        num = 16'd34;
        @(posedge clk); #2;
        for (int i = 0; i < 2000; i++) begin
            if (num_ready) break;
            @(posedge clk); #2;
        end
        @(posedge clk); #1;
        num_valid = 1'b0;
        wait_bytes(6, ok, rh, bl);
        repeat (40) @(posedge clk);
        #2;
        checks++; if (!ok || q_to_hex() != "31 32 0a 33 34 0a ") begin
            errors++; $display("FAIL b2b_bytes: got %s expected 31 32 0a 33 34 0a", q_to_hex());
        end
        if (rx_start_q.size() >= 4 && rx_end_q.size() >= 3) begin
            checks++; if (rx_start_q[3] - rx_end_q[2] - 1 > 18) begin
                errors++; $display("FAIL b2b_gap: got %0d idle cycles expected <= 18", rx_start_q[3] - rx_end_q[2] - 1);
            end
        end else begin
            checks++; errors++; $display("FAIL b2b_stamps: got %0d starts expected >= 4", rx_start_q.size());
        end
        checks++; if (rx_frame_err !== 0) begin errors++; $display("FAIL b2b_framing: got %0d expected 0", rx_frame_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_extremes();
        test_ignore_busy();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1085, meaning clk cycles per UART bit (115200 baud at 125 MHz).
REQ-002 SHALL have parameter NUM_WIDTH, default 16, meaning the result operand width, fixed at 16 in this revision.
REQ-003 SHALL have port clk, input, 1, the single clock; one clock only, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port num_valid, input, 1, result-available strobe from the evaluator.
REQ-006 SHALL have port num, input, 16, the result value.
REQ-007 SHALL have port num_ready, output, 1, block idle and able to accept a result.
REQ-008 SHALL have port tx_out, output, 1, UART serial line: 8N1, LSB first, idle high.
REQ-009 SHALL have port busy, output, 1, asserted from accept until the '\n' stop bit completes.

Function
REQ-010 SHALL accept num in the cycle where num_valid && num_ready are both high, and SHALL drop num_ready in the following cycle.
REQ-011 SHALL ignore num_valid while num_ready is low; no queueing, no corruption of the in-flight result.
REQ-012 SHALL convert the captured value to decimal BCD sequentially with shift-add-3 (double-dabble) over exactly 16 cycles in state CONVERT.
REQ-013 SHALL emit ASCII digits most significant first, suppress leading zeros, emit a single '0' for value zero, then emit '\n' (0x0A).
REQ-014 SHALL frame each byte as: start bit 0, 8 data bits LSB first, stop bit 1, each bit held exactly CLKS_PER_BIT cycles.
REQ-015 SHALL send frames back to back, with the next start bit in the cycle after the previous stop bit ends.
REQ-016 SHALL use states IDLE -> CONVERT -> (SIGN) -> DIGIT -> NEWLINE -> IDLE.
- SIGN is entered only when the value is negative and the signed feature is compiled in (REQ-022).
- DIGIT loops until the units digit has been sent.
REQ-017 SHALL make the first start bit begin no later than 18 cycles after the accept cycle.
REQ-018 SHALL hold tx_out high in IDLE and CONVERT.
REQ-019 SHALL raise num_ready and drop busy in the cycle after the '\n' stop bit completes, so a result can be accepted back to back.

Reset
REQ-020 SHALL, while rst is high, force tx_out=1, num_ready=1, busy=0, state=IDLE, and clear the bit counter, baud counter and BCD registers, regardless of clock.
REQ-021 SHALL, on reset asserted mid-frame, return tx_out high immediately and SHALL NOT resume the aborted frame after reset is released.

Configuration
REQ-022 SHALL support macro RESULT_TX_SIGNED_EN.
- Defined: num is two's complement; negative values emit '-' (0x2D) followed by the magnitude digits.
- Undefined: num is unsigned, range 0..65535, and no '-' is ever emitted.

Structure
REQ-023 SHALL place the state enum typedef, the ASCII constants ('0', '-', '\n') and the default CLKS_PER_BIT in the shared package rpn_pkg.
REQ-024 SHALL instantiate one sub-module, uart_tx_byte, as the byte serializer.
- Inputs: byte, start. Outputs: tx, done.
- Parameter: CLKS_PER_BIT.
- The top module owns conversion and sequencing.

Verification (CLKS_PER_BIT=4; a bench UART receiver decodes tx_out)
REQ-025 SHALL check num=25 -> bytes "2","5","\n" (0x32, 0x35, 0x0A); num_ready low throughout, high after the last stop bit.
REQ-026 SHALL check num=0 -> "0\n" exactly, with no extra characters.
REQ-027 SHALL check, without RESULT_TX_SIGNED_EN, num=16'hFFFF -> "65535\n"; with it, num=16'h8000 -> "-32768\n" and num=16'hFFFF -> "-1\n".
REQ-028 SHALL check num=7 accepted, then num=9 with num_valid pulsed during transmission -> only "7\n" is sent, and 9 is never sent.
REQ-029 SHALL check that rst asserted during the data bits of the second character returns tx_out=1 and num_ready=1 at once; a new num=3 afterwards -> "3\n" with correct framing.
REQ-030 SHALL check two results presented back to back with num_valid held high -> both strings sent in order, with no idle gap longer than 18 cycles between them.
